// File: rtl/output_pkg.sv
// ============================================================================
// output_pkg : shared FSM encoding and display limits for output_arbiter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package output_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CONV_BITS_DEFAULT = 10;
    localparam int MAX_DISPLAY       = 999;

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_step.sv
// ============================================================================
// bcd_dabble_step : one combinational double-dabble iteration on 3 BCD digits
// Revision        : 1.0
// ============================================================================
`default_nettype none

module bcd_dabble_step
    import output_pkg::*;
(
    input  logic [3:0] hun_i,
    input  logic [3:0] ten_i,
    input  logic [3:0] one_i,
    input  logic       bit_i,
    output logic [3:0] hun_o,
    output logic [3:0] ten_o,
    output logic [3:0] one_o
);

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    logic [12:0] w_shift;

    // The carry out of the hundreds digit is dropped; overflow is flagged upstream.
    assign w_shift = {add3(hun_i), add3(ten_i), add3(one_i), bit_i};
    assign {hun_o, ten_o, one_o} = 12'(w_shift);

endmodule

`default_nettype wire

// File: rtl/output_arbiter.sv
// ============================================================================
// output_arbiter : round-robin CPU/debug display arbiter with serial BCD convert
// Revision       : 1.0
// ============================================================================
`default_nettype none

module output_arbiter
    import output_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CONV_BITS = CONV_BITS_DEFAULT
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              dbg_req,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              cpu_ack,
    output logic              dbg_ack,
    output logic              busy,
    output logic [3:0]        bcd_hundreds,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones,
    output logic              neg,
    output logic              ovf,
    output logic              valid
);

    localparam int CNT_W = (CONV_BITS > 1) ? $clog2(CONV_BITS) : 1;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CONV_BITS-1:0]   mag_q;
    logic                   work_neg_q, work_ovf_q;
    logic                   gnt_dbg_q, last_dbg_q;
    logic [3:0]             hun_q, ten_q, one_q;
    logic [3:0]             hun_d, ten_d, one_d;
    logic [3:0]             out_hun_q, out_ten_q, out_one_q;
    logic                   out_neg_q, out_ovf_q, valid_q;
    logic                   cpu_ack_q, dbg_ack_q;

    logic                   w_pick_dbg;
    logic [DATA_W-1:0]      w_data, w_mag;
    logic                   w_neg, w_ovf;

    // Debug wins a tie only when the CPU was granted last.
    assign w_pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
    assign w_data     = w_pick_dbg ? dbg_data : cpu_data;
    assign w_neg      = w_data[DATA_W-1];
    assign w_mag      = w_neg ? ~(w_data - DATA_W'(1)) : w_data;
    assign w_ovf      = w_mag > DATA_W'(MAX_DISPLAY);

    bcd_dabble_step u_step (
        .hun_i (hun_q),
        .ten_i (ten_q),
        .one_i (one_q),
        .bit_i (mag_q[cnt_q]),
        .hun_o (hun_d),
        .ten_o (ten_d),
        .one_o (one_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            work_neg_q <= 1'b0;
            work_ovf_q <= 1'b0;
            gnt_dbg_q  <= 1'b0;
            last_dbg_q <= 1'b1;
            hun_q      <= '0;
            ten_q      <= '0;
            one_q      <= '0;
            out_hun_q  <= '0;
            out_ten_q  <= '0;
            out_one_q  <= '0;
            out_neg_q  <= 1'b0;
            out_ovf_q  <= 1'b0;
            valid_q    <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dbg_ack_q  <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req || dbg_req) begin
                        gnt_dbg_q  <= w_pick_dbg;
                        last_dbg_q <= w_pick_dbg;
                        mag_q      <= w_mag[CONV_BITS-1:0];
                        work_neg_q <= w_neg;
                        work_ovf_q <= w_ovf;
                        hun_q      <= '0;
                        ten_q      <= '0;
                        one_q      <= '0;
                        cnt_q      <= CNT_W'(CONV_BITS - 1);
                        state_q    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    hun_q <= hun_d;
                    ten_q <= ten_d;
                    one_q <= one_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        out_hun_q <= work_ovf_q ? 4'd9 : hun_d;
                        out_ten_q <= work_ovf_q ? 4'd9 : ten_d;
                        out_one_q <= work_ovf_q ? 4'd9 : one_d;
                        out_neg_q <= work_neg_q;
                        out_ovf_q <= work_ovf_q;
                        valid_q   <= 1'b1;
                        cpu_ack_q <= ~gnt_dbg_q;
                        dbg_ack_q <= gnt_dbg_q;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign cpu_ack      = cpu_ack_q;
    assign dbg_ack      = dbg_ack_q;
    assign bcd_hundreds = out_hun_q;
    assign bcd_tens     = out_ten_q;
    assign bcd_ones     = out_one_q;
    assign neg          = out_neg_q;
    assign ovf          = out_ovf_q;
    assign valid        = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_output_arbiter.sv
// ============================================================================
// tb_output_arbiter : scoreboard bench for output_arbiter (directed vectors)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_output_arbiter;

    typedef struct packed {
        logic       dbg;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       n;
        logic       v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        dbg_req = 1'b0;
    logic [31:0] cpu_data = '0;
    logic [31:0] dbg_data = '0;
    logic        cpu_ack, dbg_ack, busy, neg, ovf, valid;
    logic [3:0]  bcd_hundreds, bcd_tens, bcd_ones;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_cnt  = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [14:0] prev_out = '0;

    output_arbiter #(.DATA_W(32), .CONV_BITS(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_data     (cpu_data),
        .dbg_req      (dbg_req),
        .dbg_data     (dbg_data),
        .cpu_ack      (cpu_ack),
        .dbg_ack      (dbg_ack),
        .busy         (busy),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones),
        .neg          (neg),
        .ovf          (ovf),
        .valid        (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] out_vec();
        return {bcd_hundreds, bcd_tens, bcd_ones, neg, ovf, valid};
    endfunction

    // Monitor: every ack is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (cpu_ack || dbg_ack)) begin
            ack_cnt++;
            check("single_ack", {63'd0, cpu_ack & dbg_ack}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {62'd0, cpu_ack, dbg_ack}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {47'd0, dbg_ack, cpu_ack, out_vec()},
                      {47'd0, mon_e.dbg, ~mon_e.dbg, mon_e.h, mon_e.t, mon_e.o, mon_e.n, mon_e.v, 1'b1});
            end
        end
    end

    task automatic run_req(input logic dbg, input logic [31:0] d,
                           input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                           input logic n, input logic v, input int mutate_at);
        exp_t e;
        int   cyc;
        logic hold_ok;
        logic seen;
        e.dbg = dbg; e.h = h; e.t = t; e.o = o; e.n = n; e.v = v;
        exp_q.push_back(e);
        @(negedge clk);
        if (dbg) begin dbg_data = d; dbg_req = 1'b1; end
        else     begin cpu_data = d; cpu_req = 1'b1; end
        @(posedge clk); #1;
        check("busy_after_grant", {63'd0, busy}, 64'd1);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        hold_ok = 1'b1;
        seen    = 1'b0;
        cyc     = 0;
        while (!seen && cyc < 40) begin
            if (cyc == mutate_at) begin
                cpu_data = 32'd456;
                dbg_data = 32'd456;
            end
            @(posedge clk); #1;
            cyc++;
            if (cpu_ack || dbg_ack) seen = 1'b1;
            else if (out_vec() !== prev_out) hold_ok = 1'b0;
        end
        check("ack_latency", 64'(cyc), 64'd10);
        check("hold_during_conv", {63'd0, hold_ok}, 64'd1);
        prev_out = {h, t, o, n, v, 1'b1};
        @(posedge clk); #1;
    endtask

    initial begin
        int start;

        #1;
        check("reset_outputs", {51'd0, out_vec(), busy, cpu_ack, dbg_ack}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held: CPU, DBG, CPU.
        begin
            exp_t e;
            e = '{dbg:1'b0, h:4'd0, t:4'd0, o:4'd7, n:1'b0, v:1'b0}; exp_q.push_back(e);
            e = '{dbg:1'b1, h:4'd2, t:4'd5, o:4'd0, n:1'b0, v:1'b0}; exp_q.push_back(e);
            e = '{dbg:1'b0, h:4'd0, t:4'd0, o:4'd7, n:1'b0, v:1'b0}; exp_q.push_back(e);
        end
        start = ack_cnt;
        @(negedge clk);
        cpu_data = 32'd7;  cpu_req = 1'b1;
        dbg_data = 32'd250; dbg_req = 1'b1;
        for (int i = 0; i < 100 && ack_cnt < start + 3; i++) begin
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check("rr_ack_count", 64'(ack_cnt - start), 64'd3);
        @(posedge clk); #1;
        check("rr_idle", {63'd0, busy}, 64'd0);
        prev_out = {4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1};

        run_req(1'b0, 32'd123,        4'd1, 4'd2, 4'd3, 1'b0, 1'b0, -1);
        run_req(1'b1, 32'hFFFF_FFD3,  4'd0, 4'd4, 4'd5, 1'b1, 1'b0, -1);
        run_req(1'b0, 32'd1000,       4'd9, 4'd9, 4'd9, 1'b0, 1'b1, -1);
        run_req(1'b0, 32'h8000_0000,  4'd9, 4'd9, 4'd9, 1'b1, 1'b1, -1);
        run_req(1'b1, 32'd0,          4'd0, 4'd0, 4'd0, 1'b0, 1'b0, -1);
        run_req(1'b0, 32'd999,        4'd9, 4'd9, 4'd9, 1'b0, 1'b0, -1);
        run_req(1'b1, 32'hFFFF_FFFF,  4'd0, 4'd0, 4'd1, 1'b1, 1'b0, -1);

        // Abort a conversion with the counter at 4.
        start = ack_cnt;
        @(negedge clk);
        cpu_data = 32'd500;
        cpu_req  = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {51'd0, out_vec(), busy, cpu_ack, dbg_ack}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_out = '0;
        repeat (15) @(posedge clk);
        #1;
        check("no_ack_after_abort", 64'(ack_cnt - start), 64'd0);
        check("idle_after_abort", {63'd0, busy}, 64'd0);

        // Data changed two cycles after grant must not disturb the result.
        run_req(1'b0, 32'd123, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 2);

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
